// File: rtl/vga_scan_counter.sv
// -----------------------------------------------------------------------------
// vga_scan_counter
//
// Raster position generator for a VGA-style display pipeline. A clock divider
// produces one pixel strobe every CLK_DIV system clocks. Column and row
// counters advance on that strobe. Frame-boundary strobes are decoded from the
// registered position.
//
// Parameters
//   CLK_DIV   system clocks per pixel (2..16)
//   H_TOTAL   pixel clocks per line, including blanking
//   V_TOTAL   lines per frame, including blanking
//   V_ACTIVE  visible lines per frame
//
// Ports
//   clk          in   system clock, rising-edge active
//   rst_n        in   asynchronous active-low reset
//   run          in   count enable; low freezes every counter
//   row          out  current line, 0..V_TOTAL-1 (registered)
//   col          out  current pixel in line, 0..H_TOTAL-1 (registered)
//   pix_en       out  one-clk strobe, once per pixel period
//   line_end     out  one-clk strobe on the last pixel of a line
//   frame_end    out  one-clk strobe on the last pixel of a frame
//   vblank_tick  out  one-clk strobe on the last pixel of the last visible line
//   frame_count  out  frames completed since reset, modulo 256
//
// Handshake: there is no valid/ready pair. pix_en acts as the qualifier for
// the position. While pix_en is high, row/col name the pixel that is ending.
// The position moves to the next pixel on that same clock edge.
// -----------------------------------------------------------------------------
module vga_scan_counter #(
    parameter int CLK_DIV  = 4,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [15:0] row,
    output logic [15:0] col,
    output logic        pix_en,
    output logic        line_end,
    output logic        frame_end,
    output logic        vblank_tick,
    output logic [7:0]  frame_count
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0]     COL_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0]     ROW_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0]     VIS_LAST = 16'(V_ACTIVE - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [15:0]      r_row;
    logic [15:0]      r_col;
    logic [7:0]       r_frame_count;

    logic w_pix_en;
    logic w_line_end;
    logic w_frame_end;
    logic w_vblank_tick;

    // The strobes are decoded from registered state, gated by run.
    // Reset clears r_div_cnt to 0. CLK_DIV is at least 2, so DIV_LAST is
    // never 0. That means every strobe is already low while reset is held.
    assign w_pix_en      = run & (r_div_cnt == DIV_LAST);
    assign w_line_end    = w_pix_en & (r_col == COL_LAST);
    assign w_frame_end   = w_line_end & (r_row == ROW_LAST);
    assign w_vblank_tick = w_line_end & (r_row == VIS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_frame_count <= '0;
        end else if (run) begin
            // A held divider resumes from its held value when run returns.
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            // Wrap points are exact terminal values; downstream decode
            // relies on col/row never passing H_TOTAL-1 / V_TOTAL-1.
            if (w_pix_en) begin
                if (w_line_end) begin
                    r_col <= '0;
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end

            if (w_line_end) begin
                if (w_frame_end) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 16'd1;
                end
            end

            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign row         = r_row;
    assign col         = r_col;
    assign frame_count = r_frame_count;
    assign pix_en      = w_pix_en;
    assign line_end    = w_line_end;
    assign frame_end   = w_frame_end;
    assign vblank_tick = w_vblank_tick;

endmodule

// File: tb/tb_vga_scan_counter.sv
// -----------------------------------------------------------------------------
// Testbench for vga_scan_counter, using a small raster so that more than 256
// frames fit in a short run.
//
// The reference model counts the enabled system clocks since reset. It derives
// the full position and strobe set from that count with plain division and
// modulo.
// -----------------------------------------------------------------------------
module tb_vga_scan_counter;

  localparam int D  = 3;
  localparam int H  = 8;
  localparam int V  = 5;
  localparam int VA = 3;
  localparam longint FRAME_CLKS = D * H * V;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic run;
  always #5 clk = ~clk;

  logic [15:0] row;
  logic [15:0] col;
  logic        pix_en;
  logic        line_end;
  logic        frame_end;
  logic        vblank_tick;
  logic [7:0]  frame_count;

  vga_scan_counter #(
    .CLK_DIV  (D),
    .H_TOTAL  (H),
    .V_TOTAL  (V),
    .V_ACTIVE (VA)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .row         (row),
    .col         (col),
    .pix_en      (pix_en),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .vblank_tick (vblank_tick),
    .frame_count (frame_count)
  );

  // Packed observation: {row, col, pix_en, line_end, frame_end, vblank_tick, frame_count}
  logic [43:0] dut_vec;
  assign dut_vec = {row, col, pix_en, line_end, frame_end, vblank_tick, frame_count};

  // ---------------- scoreboard state ----------------
  logic [43:0] exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint n = 0;        // enabled clock edges since reset (model state)
  int     exp_lines = 0;
  int     exp_frames = 0;
  int     obs_lines = 0;
  int     obs_frames = 0;
  bit     obs_wrap = 1'b0;
  bit     prev_valid = 1'b0;
  logic [7:0] prev_fc = 8'd0;

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [43:0] model(input longint cnt, input bit r);
    longint div, pix, c, line, rw, fr;
    bit pe, le, fe, vb;
    div  = cnt % D;
    pix  = cnt / D;
    c    = pix % H;
    line = pix / H;
    rw   = line % V;
    fr   = (line / V) % 256;
    pe   = r && (div == D - 1);
    le   = pe && (c == H - 1);
    fe   = le && (rw == V - 1);
    vb   = le && (rw == VA - 1);
    return {16'(rw), 16'(c), pe, le, fe, vb, 8'(fr)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_exp(input bit r);
    logic [43:0] e;
    e = model(n, r);
    exp_q.push_back(e);
    exp_lines  += int'(e[10]);
    exp_frames += int'(e[9]);
  endtask

  task automatic drive_cycle(input bit r);
    @(posedge clk);
    #1;
    run = r;
    push_exp(r);
    if (rst_n) n += longint'(r);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b0;
    n     = 0;
    push_exp(1'b0);
  endtask

  // Reset is asserted between clock edges, and the outputs are checked before
  // the next edge arrives.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec, 44'd0);
    n = 0;
    prev_valid = 1'b0;
    repeat (hold) drive_cycle($urandom_range(0, 1) == 1);
    release_reset();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [43:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scan_state", dut_vec, e);
      obs_lines  += int'(line_end);
      obs_frames += int'(frame_end);
      if (prev_valid && prev_fc == 8'd255 && frame_count == 8'd0) obs_wrap = 1'b1;
      prev_fc    = frame_count;
      prev_valid = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    #2;
    check("reset_state", dut_vec, 44'd0);
    release_reset();

    // Mostly free-running operation, mixed with random run gaps, long holds
    // and occasional mid-frame resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 299) == 0) begin
        repeat (50) drive_cycle(1'b0);
      end else begin
        drive_cycle($urandom_range(0, 3) != 0);
      end
    end

    // Run more than 256 frames from a fresh reset so that frame_count wraps.
    do_reset(2);
    for (int i = 0; i < 60000 && n < 257 * FRAME_CLKS; i++) begin
      drive_cycle($urandom_range(0, 9) != 0);
    end
    if (n < 257 * FRAME_CLKS) begin
      checks++;
      errors++;
      $display("FAIL frame_budget actual=%0d expected>=%0d", n, 257 * FRAME_CLKS);
    end

    @(negedge clk);
    @(negedge clk);
    check("line_end_count", 44'(obs_lines), 44'(exp_lines));
    check("frame_end_count", 44'(obs_frames), 44'(exp_frames));
    check("frame_count_wrap", 44'(obs_wrap), 44'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
